// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Round-robin arbiter for the single register-file write port, shared by
//   the ALU (req0) and the LSU/multicycle unit (req1).  The granted request
//   is registered onto we3/wa3/wd3 one cycle after acceptance.  Writes to
//   rd=0 are accepted but never raise we3.
//
//   Optional scoreboard (define RF_WB_SCOREBOARD_EN): a pending bit per
//   register is set on issue and cleared on the edge that commits the write.
//   It provides RAW hazard flags for two read ports and stalls an issue whose
//   destination is still pending (WAW).  Without the macro, haz1/haz2 are 0,
//   iss_ready is 1 and no pending storage exists.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0_valid/ready/rd/data   ALU writeback request
//   req1_valid/ready/rd/data   LSU/multicycle writeback request
//   iss_valid/ready, iss_rd    issue handshake and claimed destination
//   ra1, ra2 -> haz1, haz2     read addresses and their hazard flags
//   we3, wa3, wd3              register-file write port

module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        haz1,
  output logic        haz2,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3
);

  typedef enum logic {
    FAV_REQ0 = 1'b0,
    FAV_REQ1 = 1'b1
  } rr_t;

  rr_t  ptr_q, ptr_d;
  logic acc0, acc1;

  // Priority only matters when both are valid; a lone requester always wins.
  always_comb begin
    req0_ready = req0_valid & (~req1_valid | (ptr_q == FAV_REQ0));
    req1_ready = req1_valid & (~req0_valid | (ptr_q == FAV_REQ1));
  end

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (acc0)      ptr_d = FAV_REQ1;
    else if (acc1) ptr_d = FAV_REQ0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= FAV_REQ0;
    else        ptr_q <= ptr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (acc0) begin
      we3 <= |req0_rd;
      wa3 <= req0_rd;
      wd3 <= req0_data;
    end else if (acc1) begin
      we3 <= |req1_rd;
      wa3 <= req1_rd;
      wd3 <= req1_data;
    end else begin
      we3 <= 1'b0;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] pend_q, pend_d;
  logic        iss_acc;

  assign iss_ready = ~pend_q[iss_rd];
  assign iss_acc   = iss_valid & iss_ready & (iss_rd != 5'd0);
  assign haz1      = pend_q[ra1];
  assign haz2      = pend_q[ra2];

  // Clear is applied before set so a same-edge issue to the committing
  // register keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (we3)     pend_d[wa3]    = 1'b0;
    if (iss_acc) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, ra1, ra2};
  assign iss_ready = 1'b1;
  assign haz1      = 1'b0;
  assign haz2      = 1'b0;
`endif

endmodule
